// File: rtl/fwd_pkg.sv
// Shared constants for the forwarding scoreboard: select encoding, operand packing and depth bound.
package fwd_pkg;

   localparam int FWD_SEL_RF    = 0;
   localparam int FWD_MAX_DEPTH = 7;

   // Operand k of a packed source bus starts at this bit.
   function automatic int srcLsb(input int k, input int width);
      return k * width;
   endfunction

endpackage

// File: rtl/forwarding_scoreboard_if.sv
// Pipeline-side signal bundle of the forwarding scoreboard; the scoreboard is the slave.
interface forwarding_scoreboard_if #(
   parameter int NUM_SRC = 2,
   parameter int REG_AW  = 5,
   parameter int SEL_W   = 3
);
   logic                      hold_i;
   logic                      flush_i;
   logic                      ex_valid_i;
   logic [REG_AW-1:0]         ex_rd_i;
   logic                      ex_regwrite_i;
   logic                      ex_memread_i;
   logic [NUM_SRC*REG_AW-1:0] ex_rs_i;
   logic [NUM_SRC*REG_AW-1:0] id_rs_i;
   logic [NUM_SRC*SEL_W-1:0]  fwd_sel_o;
   logic                      load_use_stall_o;
   logic [31:0]               fwd_count_o;
   logic [31:0]               stall_count_o;

   modport master (
      output hold_i, flush_i, ex_valid_i, ex_rd_i, ex_regwrite_i, ex_memread_i, ex_rs_i, id_rs_i,
      input  fwd_sel_o, load_use_stall_o, fwd_count_o, stall_count_o
   );

   modport slave (
      input  hold_i, flush_i, ex_valid_i, ex_rd_i, ex_regwrite_i, ex_memread_i, ex_rs_i, id_rs_i,
      output fwd_sel_o, load_use_stall_o, fwd_count_o, stall_count_o
   );
endinterface

// File: rtl/fwd_src_match.sv
// Priority match of one EX source against the in-flight destination history; youngest stage wins.
module fwd_src_match
   import fwd_pkg::*;
#(
   parameter int DEPTH  = 2,
   parameter int REG_AW = 5,
   parameter int SEL_W  = 3
) (
   input  logic [DEPTH-1:0]        histValid,
   input  logic [DEPTH*REG_AW-1:0] histRd,
   input  logic [REG_AW-1:0]       rs,
   output logic [SEL_W-1:0]        sel
);

   // Scan oldest to youngest so a younger hit overwrites an older one.
   always_comb begin
      sel = SEL_W'(FWD_SEL_RF);
      for (int s = DEPTH; s >= 1; s--) begin
         if (histValid[s-1] && (histRd[(s-1)*REG_AW +: REG_AW] == rs)) begin
            sel = SEL_W'(s);
         end
      end
   end

endmodule

// File: rtl/forwarding_scoreboard.sv
// Forwarding/hazard unit beside EX: destination history, per-source bypass selects, load-use stall.
// Optional saturating statistics counters are built when FWD_STATS_EN is defined.
module forwarding_scoreboard
   import fwd_pkg::*;
#(
   parameter int NUM_SRC = 2,
   parameter int DEPTH   = 2,
   parameter int REG_AW  = 5,
   parameter int SEL_W   = 3
) (
   input logic                    clk_i,
   input logic                    rst_i,
   forwarding_scoreboard_if.slave bus
);

   // Bit/field s-1 holds stage s; stage 1 is the youngest (MEM).
   logic [DEPTH-1:0]         histValid;
   logic [DEPTH*REG_AW-1:0]  histRd;
   logic                     enterHist;
   logic                     stall;
   logic [NUM_SRC-1:0]       idHit;
   logic [NUM_SRC*SEL_W-1:0] selFlat;

   // x0 is never entered, so an x0 source can never match.
   assign enterHist = bus.ex_valid_i & bus.ex_regwrite_i & ~bus.flush_i & (bus.ex_rd_i != '0);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         histValid <= '0;
         histRd    <= '0;
      end else if (!bus.hold_i) begin
         histValid <= (histValid << 1) | DEPTH'(enterHist);
         histRd    <= (histRd << REG_AW) | (DEPTH*REG_AW)'(bus.ex_rd_i);
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
         fwd_src_match #(
            .DEPTH  (DEPTH),
            .REG_AW (REG_AW),
            .SEL_W  (SEL_W)
         ) u_match (
            .histValid (histValid),
            .histRd    (histRd),
            .rs        (bus.ex_rs_i[srcLsb(gi, REG_AW) +: REG_AW]),
            .sel       (selFlat[gi*SEL_W +: SEL_W])
         );

         assign idHit[gi] = (bus.id_rs_i[srcLsb(gi, REG_AW) +: REG_AW] == bus.ex_rd_i);
      end
   endgenerate

   // Only stage 1 is too early for load data; older stages already hold it.
   assign stall = enterHist & bus.ex_memread_i & (|idHit);

   assign bus.fwd_sel_o        = selFlat;
   assign bus.load_use_stall_o = stall;

`ifdef FWD_STATS_EN
   localparam int INC_W = $clog2(NUM_SRC + 1);

   logic [31:0]      fwdCount;
   logic [31:0]      stallCount;
   logic [INC_W-1:0] fwdInc;
   logic [32:0]      fwdSum;

   always_comb begin
      fwdInc = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         if (selFlat[k*SEL_W +: SEL_W] != SEL_W'(FWD_SEL_RF)) begin
            fwdInc = fwdInc + INC_W'(1);
         end
      end
      fwdSum = {1'b0, fwdCount} + 33'(fwdInc);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         fwdCount   <= '0;
         stallCount <= '0;
      end else if (!bus.hold_i) begin
         if (bus.ex_valid_i) begin
            fwdCount <= fwdSum[32] ? 32'hFFFF_FFFF : fwdSum[31:0];
         end
         if (stall && (stallCount != 32'hFFFF_FFFF)) begin
            stallCount <= stallCount + 32'd1;
         end
      end
   end

   assign bus.fwd_count_o   = fwdCount;
   assign bus.stall_count_o = stallCount;
`else
   assign bus.fwd_count_o   = '0;
   assign bus.stall_count_o = '0;
`endif

endmodule

// File: tb/tb_forwarding_scoreboard.sv
// Directed bench for forwarding_scoreboard (NUM_SRC=2, DEPTH=2, default build without statistics).
module tb_forwarding_scoreboard;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   nvec = 0;
   int   nerr = 0;

   always #5 clk = ~clk;

   forwarding_scoreboard_if #(.NUM_SRC(2), .REG_AW(5), .SEL_W(3)) bus ();

   forwarding_scoreboard #(
      .NUM_SRC (2),
      .DEPTH   (2),
      .REG_AW  (5),
      .SEL_W   (3)
   ) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus.slave)
   );

   logic [2:0] sel0;
   logic [2:0] sel1;
   assign sel0 = bus.fwd_sel_o[2:0];
   assign sel1 = bus.fwd_sel_o[5:3];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_ex(input logic v, input logic [4:0] rd, input logic rw, input logic mr,
                           input logic [4:0] rs1, input logic [4:0] rs2);
      bus.ex_valid_i    = v;
      bus.ex_rd_i       = rd;
      bus.ex_regwrite_i = rw;
      bus.ex_memread_i  = mr;
      bus.ex_rs_i       = {rs2, rs1};
   endtask

   task automatic apply_reset();
      drive_ex(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0);
      bus.id_rs_i = '0;
      bus.hold_i  = 1'b0;
      bus.flush_i = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      apply_reset();
      step();
      nvec++; if (sel0 !== 3'd0) begin nerr++; $display("FAIL reset_sel0: got %0d want 0", sel0); end
      else $display("ok   reset_sel0 = %0d", sel0);
      nvec++; if (sel1 !== 3'd0) begin nerr++; $display("FAIL reset_sel1: got %0d want 0", sel1); end
      else $display("ok   reset_sel1 = %0d", sel1);
      nvec++; if (bus.load_use_stall_o !== 1'b0) begin nerr++; $display("FAIL reset_stall: got %b want 0", bus.load_use_stall_o); end
      else $display("ok   reset_stall = %b", bus.load_use_stall_o);
      nvec++; if (bus.fwd_count_o !== 32'd0) begin nerr++; $display("FAIL reset_fwd_count: got %0d want 0", bus.fwd_count_o); end
      else $display("ok   reset_fwd_count = %0d", bus.fwd_count_o);
      nvec++; if (bus.stall_count_o !== 32'd0) begin nerr++; $display("FAIL reset_stall_count: got %0d want 0", bus.stall_count_o); end
      else $display("ok   reset_stall_count = %0d", bus.stall_count_o);
   endtask

   task automatic test_single_producer();
      apply_reset();
      drive_ex(1'b1, 5'd5, 1'b1, 1'b0, 5'd0, 5'd0);
      step();
      drive_ex(1'b1, 5'd0, 1'b0, 1'b0, 5'd5, 5'd0);
      #1;
      nvec++; if (sel0 !== 3'd1) begin nerr++; $display("FAIL single_stage1: got %0d want 1", sel0); end
      else $display("ok   single_stage1 = %0d", sel0);
      nvec++; if (sel1 !== 3'd0) begin nerr++; $display("FAIL single_other_src: got %0d want 0", sel1); end
      else $display("ok   single_other_src = %0d", sel1);
      step();
      nvec++; if (sel0 !== 3'd2) begin nerr++; $display("FAIL single_stage2: got %0d want 2", sel0); end
      else $display("ok   single_stage2 = %0d", sel0);
      step();
      nvec++; if (sel0 !== 3'd0) begin nerr++; $display("FAIL single_dropped: got %0d want 0", sel0); end
      else $display("ok   single_dropped = %0d", sel0);
   endtask

   task automatic test_back_to_back();
      apply_reset();
      drive_ex(1'b1, 5'd7, 1'b1, 1'b0, 5'd0, 5'd0);
      step();
      step();
      drive_ex(1'b1, 5'd0, 1'b0, 1'b0, 5'd7, 5'd7);
      #1;
      nvec++; if (sel0 !== 3'd1) begin nerr++; $display("FAIL b2b_youngest_rs1: got %0d want 1", sel0); end
      else $display("ok   b2b_youngest_rs1 = %0d", sel0);
      nvec++; if (sel1 !== 3'd1) begin nerr++; $display("FAIL b2b_youngest_rs2: got %0d want 1", sel1); end
      else $display("ok   b2b_youngest_rs2 = %0d", sel1);
      step();
      nvec++; if (sel0 !== 3'd2) begin nerr++; $display("FAIL b2b_older_only: got %0d want 2", sel0); end
      else $display("ok   b2b_older_only = %0d", sel0);
   endtask

   task automatic test_load_use();
      apply_reset();
      drive_ex(1'b1, 5'd9, 1'b1, 1'b1, 5'd0, 5'd0);
      bus.id_rs_i = {5'd9, 5'd0};
      #1;
      nvec++; if (bus.load_use_stall_o !== 1'b1) begin nerr++; $display("FAIL lu_rs2_hit: got %b want 1", bus.load_use_stall_o); end
      else $display("ok   lu_rs2_hit = %b", bus.load_use_stall_o);
      bus.id_rs_i = {5'd2, 5'd9};
      #1;
      nvec++; if (bus.load_use_stall_o !== 1'b1) begin nerr++; $display("FAIL lu_rs1_hit: got %b want 1", bus.load_use_stall_o); end
      else $display("ok   lu_rs1_hit = %b", bus.load_use_stall_o);
      bus.id_rs_i = {5'd3, 5'd4};
      #1;
      nvec++; if (bus.load_use_stall_o !== 1'b0) begin nerr++; $display("FAIL lu_no_match: got %b want 0", bus.load_use_stall_o); end
      else $display("ok   lu_no_match = %b", bus.load_use_stall_o);
      bus.id_rs_i = {5'd9, 5'd0};
      drive_ex(1'b1, 5'd9, 1'b1, 1'b0, 5'd0, 5'd0);
      #1;
      nvec++; if (bus.load_use_stall_o !== 1'b0) begin nerr++; $display("FAIL lu_not_load: got %b want 0", bus.load_use_stall_o); end
      else $display("ok   lu_not_load = %b", bus.load_use_stall_o);
      drive_ex(1'b1, 5'd9, 1'b1, 1'b1, 5'd0, 5'd0);
      bus.flush_i = 1'b1;
      #1;
      nvec++; if (bus.load_use_stall_o !== 1'b0) begin nerr++; $display("FAIL lu_flushed: got %b want 0", bus.load_use_stall_o); end
      else $display("ok   lu_flushed = %b", bus.load_use_stall_o);
      step();
      bus.flush_i = 1'b0;
      bus.id_rs_i = '0;
      drive_ex(1'b1, 5'd0, 1'b0, 1'b0, 5'd9, 5'd9);
      #1;
      nvec++; if (sel0 !== 3'd0) begin nerr++; $display("FAIL lu_flush_no_entry: got %0d want 0", sel0); end
      else $display("ok   lu_flush_no_entry = %0d", sel0);
      drive_ex(1'b1, 5'd9, 1'b1, 1'b1, 5'd0, 5'd0);
      step();
      drive_ex(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd9);
      #1;
      nvec++; if (sel1 !== 3'd1) begin nerr++; $display("FAIL lu_load_bypass: got %0d want 1", sel1); end
      else $display("ok   lu_load_bypass = %0d", sel1);
   endtask

   task automatic test_x0();
      apply_reset();
      drive_ex(1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 5'd0);
      bus.id_rs_i = '0;
      #1;
      nvec++; if (bus.load_use_stall_o !== 1'b0) begin nerr++; $display("FAIL x0_no_stall: got %b want 0", bus.load_use_stall_o); end
      else $display("ok   x0_no_stall = %b", bus.load_use_stall_o);
      step();
      drive_ex(1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0);
      #1;
      nvec++; if (sel0 !== 3'd0) begin nerr++; $display("FAIL x0_no_fwd_rs1: got %0d want 0", sel0); end
      else $display("ok   x0_no_fwd_rs1 = %0d", sel0);
      nvec++; if (sel1 !== 3'd0) begin nerr++; $display("FAIL x0_no_fwd_rs2: got %0d want 0", sel1); end
      else $display("ok   x0_no_fwd_rs2 = %0d", sel1);
   endtask

   task automatic test_hold_flush_reset();
      apply_reset();
      drive_ex(1'b1, 5'd3, 1'b1, 1'b0, 5'd0, 5'd0);
      step();
      bus.hold_i = 1'b1;
      drive_ex(1'b1, 5'd4, 1'b1, 1'b0, 5'd3, 5'd4);
      #1;
      nvec++; if (sel0 !== 3'd1) begin nerr++; $display("FAIL hold_start: got %0d want 1", sel0); end
      else $display("ok   hold_start = %0d", sel0);
      for (int i = 0; i < 3; i++) begin
         step();
         nvec++; if (sel0 !== 3'd1) begin nerr++; $display("FAIL hold_cycle%0d_x3: got %0d want 1", i, sel0); end
         else $display("ok   hold_cycle%0d_x3 = %0d", i, sel0);
         nvec++; if (sel1 !== 3'd0) begin nerr++; $display("FAIL hold_cycle%0d_x4: got %0d want 0", i, sel1); end
         else $display("ok   hold_cycle%0d_x4 = %0d", i, sel1);
      end
      bus.flush_i = 1'b1;
      drive_ex(1'b1, 5'd6, 1'b1, 1'b0, 5'd3, 5'd6);
      step();
      nvec++; if (sel0 !== 3'd1) begin nerr++; $display("FAIL hold_flush_x3: got %0d want 1", sel0); end
      else $display("ok   hold_flush_x3 = %0d", sel0);
      nvec++; if (sel1 !== 3'd0) begin nerr++; $display("FAIL hold_flush_x6: got %0d want 0", sel1); end
      else $display("ok   hold_flush_x6 = %0d", sel1);
      bus.hold_i  = 1'b0;
      bus.flush_i = 1'b0;
      drive_ex(1'b1, 5'd4, 1'b1, 1'b0, 5'd3, 5'd4);
      step();
      nvec++; if (sel0 !== 3'd2) begin nerr++; $display("FAIL release_x3: got %0d want 2", sel0); end
      else $display("ok   release_x3 = %0d", sel0);
      nvec++; if (sel1 !== 3'd1) begin nerr++; $display("FAIL release_x4: got %0d want 1", sel1); end
      else $display("ok   release_x4 = %0d", sel1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      nvec++; if (sel0 !== 3'd0) begin nerr++; $display("FAIL midreset_rs1: got %0d want 0", sel0); end
      else $display("ok   midreset_rs1 = %0d", sel0);
      nvec++; if (sel1 !== 3'd0) begin nerr++; $display("FAIL midreset_rs2: got %0d want 0", sel1); end
      else $display("ok   midreset_rs2 = %0d", sel1);
   endtask

   task automatic test_stats_default();
      nvec++; if (bus.fwd_count_o !== 32'd0) begin nerr++; $display("FAIL stats_fwd_tied: got %0d want 0", bus.fwd_count_o); end
      else $display("ok   stats_fwd_tied = %0d", bus.fwd_count_o);
      nvec++; if (bus.stall_count_o !== 32'd0) begin nerr++; $display("FAIL stats_stall_tied: got %0d want 0", bus.stall_count_o); end
      else $display("ok   stats_stall_tied = %0d", bus.stall_count_o);
   endtask

   initial begin
      drive_ex(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0);
      bus.id_rs_i = '0;
      bus.hold_i  = 1'b0;
      bus.flush_i = 1'b0;
      test_reset();
      test_single_producer();
      test_back_to_back();
      test_load_use();
      test_x0();
      test_hold_flush_reset();
      test_stats_default();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
      $fatal(1);
   end

endmodule
